// File: rtl/mdu_sched_if.sv
// Issue/result bundle between the Execute stage and the multiply/divide scheduler.
// The master side issues operations; the slave side (mdu_sched) returns busy and HI/LO data.
interface mdu_sched_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        mdu_active;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rdata;

   modport master (
      output start, op, a, b,
      input  busy, mdu_active, hi, lo, rdata
   );

   modport slave (
      input  start, op, a, b,
      output busy, mdu_active, hi, lo, rdata
   );
endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: computes the result at issue, holds it pending for a fixed
// latency, then commits it to HI/LO. Also serves mthi/mtlo/mfhi/mflo.
module mdu_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   mdu_sched_if.slave mdu
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               busy_q;
   logic [31:0]        hi_q;
   logic [31:0]        lo_q;
   logic [31:0]        pend_hi;
   logic [31:0]        pend_lo;
   logic               pend_we;
   logic               is_mdu_op;

   // Low 64 bits of the product are identical for signed and unsigned operands once
   // each operand has been extended to 64 bits the right way.
   function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
      logic [63:0] ex;
      logic [63:0] ey;
      ex = sgn ? {{32{x[31]}}, x} : {32'h0, x};
      ey = sgn ? {{32{y[31]}}, y} : {32'h0, y};
      return ex * ey;
   endfunction

   // Returns {remainder, quotient}; the signed overflow case is pinned explicitly.
   function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
      logic signed [31:0] sx;
      logic signed [31:0] sy;
      logic signed [31:0] sq;
      logic signed [31:0] sr;
      sx = $signed(x);
      sy = $signed(y);
      sq = '0;
      sr = '0;
      if (y == 32'h0) begin
         return 64'h0;
      end else if (!sgn) begin
         return {x % y, x / y};
      end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         return {32'h0, 32'h8000_0000};
      end else begin
         sq = sx / sy;
         sr = sx % sy;
         return {$unsigned(sr), $unsigned(sq)};
      end
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_we <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mdu.start) begin
                  case (mdu.op)
                     OP_MULT, OP_MULTU: begin
                        {pend_hi, pend_lo} <= mul64(mdu.a, mdu.b, mdu.op == OP_MULT);
                        pend_we <= 1'b1;
                        cnt     <= CNT_W'(MULT_CYCLES);
                        busy_q  <= 1'b1;
                        state   <= RUN;
                     end
                     OP_DIV, OP_DIVU: begin
                        {pend_hi, pend_lo} <= div64(mdu.a, mdu.b, mdu.op == OP_DIV);
                        // Divide by zero still takes the full latency but never commits.
                        pend_we <= (mdu.b != 32'h0);
                        cnt     <= CNT_W'(DIV_CYCLES);
                        busy_q  <= 1'b1;
                        state   <= RUN;
                     end
                     OP_MTHI: hi_q <= mdu.a;
                     OP_MTLO: lo_q <= mdu.a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               if (cnt == CNT_W'(1)) begin
                  if (pend_we) begin
                     hi_q <= pend_hi;
                     lo_q <= pend_lo;
                  end
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign is_mdu_op      = (mdu.op >= OP_MULT) && (mdu.op <= OP_DIVU);
   assign mdu.busy       = busy_q;
   assign mdu.mdu_active = busy_q | (mdu.start & is_mdu_op);
   assign mdu.hi         = hi_q;
   assign mdu.lo         = lo_q;

   always_comb begin
      mdu.rdata = 32'h0;
      if (mdu.op == OP_MFHI) begin
         mdu.rdata = hi_q;
      end else if (mdu.op == OP_MFLO) begin
         mdu.rdata = lo_q;
      end
   end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: hand-computed multiply/divide results, busy latency,
// move-to/from HI/LO, ignored issue while busy, and reset behaviour.
module tb_mdu_sched;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   mdu_sched_if bus ();

   mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue at a negedge, then count busy cycles (bounded) and check the committed result.
   task automatic mdu_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int n_exp,
                         input logic [31:0] eh, input logic [31:0] el);
      int cycles;
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = x;
      bus.b     = y;
      #1 check({tag, "_active"}, {31'h0, bus.mdu_active}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 4'd0;
      bus.a     = 32'hDEAD_BEEF;
      bus.b     = 32'h0000_0001;
      cycles = 0;
      while (bus.busy && cycles < 40) begin
         cycles++;
         @(negedge clk);
      end
      check({tag, "_cycles"}, 32'(cycles), 32'(n_exp));
      check({tag, "_hi"}, bus.hi, eh);
      check({tag, "_lo"}, bus.lo, el);
   endtask

   initial begin
      int cycles;
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.op    = 4'd0;
      bus.a     = 32'h0;
      bus.b     = 32'h0;

      // Held in reset while issuing a multiply: nothing may start.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.start = i[0];
         bus.op    = 4'd1;
         bus.a     = 32'd3;
         bus.b     = 32'd5;
         #1;
         check("rst_busy", {31'h0, bus.busy}, 32'h0);
         check("rst_active", {31'h0, bus.mdu_active}, {31'h0, bus.start});
      end
      check("rst_hi", bus.hi, 32'h0);
      check("rst_lo", bus.lo, 32'h0);
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 4'd0;
      reset     = 1'b1;
      repeat (8) @(negedge clk);
      check("post_rst_busy", {31'h0, bus.busy}, 32'h0);
      check("post_rst_hi", bus.hi, 32'h0);
      check("post_rst_lo", bus.lo, 32'h0);
      check("rdata_none", bus.rdata, 32'h0);

      // Back-to-back operations, each issued in the first cycle busy is low.
      mdu_op("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
      mdu_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA);
      mdu_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      mdu_op("divu0", 4'd4, 32'd7,         32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      mdu_op("divov", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
      mdu_op("divu",  4'd4, 32'd100,       32'd7, 10, 32'd2, 32'd14);
      mdu_op("mults", 4'd1, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0);

      // mthi then mfhi next cycle; mtlo then mflo.
      bus.start = 1'b1;
      bus.op    = 4'd5;
      bus.a     = 32'h1234_5678;
      #1 check("mthi_active", {31'h0, bus.mdu_active}, 32'h0);
      @(negedge clk);
      check("mthi_busy", {31'h0, bus.busy}, 32'h0);
      bus.op = 4'd7;
      #1 check("mfhi_rdata", bus.rdata, 32'h1234_5678);
      @(negedge clk);
      bus.op = 4'd6;
      bus.a  = 32'hCAFE_BABE;
      @(negedge clk);
      bus.op = 4'd8;
      #1 check("mflo_rdata", bus.rdata, 32'hCAFE_BABE);
      check("mtlo_hi_kept", bus.hi, 32'h1234_5678);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 4'd9;
      #1 check("op9_active", {31'h0, bus.mdu_active}, 32'h0);
      @(negedge clk);
      check("op9_lo", bus.lo, 32'hCAFE_BABE);

      // mult 7*6 with mflo during the run and a second mult issued while busy.
      bus.start = 1'b1;
      bus.op    = 4'd1;
      bus.a     = 32'd7;
      bus.b     = 32'd6;
      @(posedge clk);
      @(negedge clk);
      cycles = 0;
      while (bus.busy && cycles < 40) begin
         cycles++;
         case (cycles)
            1: begin
               bus.start = 1'b1;
               bus.op    = 4'd8;
               #1 check("mflo_old", bus.rdata, 32'hCAFE_BABE);
            end
            2: begin
               bus.start = 1'b1;
               bus.op    = 4'd1;
               bus.a     = 32'd100;
               bus.b     = 32'd100;
               #1 check("busy_active", {31'h0, bus.mdu_active}, 32'h1);
            end
            3: begin
               bus.start = 1'b0;
               bus.op    = 4'd0;
            end
            default: ;
         endcase
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.op    = 4'd0;
      check("ign_cycles", 32'(cycles), 32'd5);
      check("ign_hi", bus.hi, 32'h0);
      check("ign_lo", bus.lo, 32'd42);
      repeat (8) @(negedge clk);
      check("ign_no_second", bus.lo, 32'd42);

      // Reset in the fourth busy cycle of a divide aborts it.
      bus.start = 1'b1;
      bus.op    = 4'd4;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 4'd0;
      repeat (3) @(negedge clk);
      check("abort_busy_pre", {31'h0, bus.busy}, 32'h1);
      reset = 1'b0;
      #1;
      check("abort_busy", {31'h0, bus.busy}, 32'h0);
      check("abort_hi", bus.hi, 32'h0);
      check("abort_lo", bus.lo, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_no_commit_hi", bus.hi, 32'h0);
      check("abort_no_commit_lo", bus.lo, 32'h0);
      check("abort_idle", {31'h0, bus.busy}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
